// File: rtl/fft16_unloader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fft16_unloader
// Description : Ping-pong frame buffer that captures one 16-lane complex
//               butterfly result per handshake and streams it out one sample
//               per cycle in natural (bit-reversed-lane) order, with optional
//               power-of-two down-scaling of every IEEE-754 output word.
// Revision    : 1.0 - initial release
// ============================================================================
module fft16_unloader #(
    parameter int SCALE_SHIFT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_real,
    input  logic [511:0] in_img,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_real,
    output logic [31:0]  out_img,
    output logic [3:0]   out_index,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [7:0] c_SHIFT = 8'(SCALE_SHIFT);

    logic [511:0] r_bank_real [2];
    logic [511:0] r_bank_img  [2];
    logic [1:0]   r_full;
    logic         r_wr_sel;
    logic         r_rd_sel;
    logic [3:0]   r_cnt;
    state_t       r_state;

    logic [1:0]   w_full_next;
    logic         w_rd_sel_next;
    logic [3:0]   w_cnt_next;
    state_t       w_state_next;
    logic         w_capture;
    logic [3:0]   w_lane;
    logic [31:0]  w_raw_real;
    logic [31:0]  w_raw_img;

    // Exponent reduction: Inf/NaN untouched, underflow flushes to signed zero.
    function automatic logic [31:0] f_scale(input logic [31:0] w);
        logic [7:0] e;
        e       = w[30:23];
        f_scale = w;
        if (SCALE_SHIFT > 0) begin
            if (e == 8'hFF) begin
                f_scale = w;
            end else if (e <= c_SHIFT) begin
                f_scale = {w[31], 31'd0};
            end else begin
                f_scale = {w[31], e - c_SHIFT, w[22:0]};
            end
        end
    endfunction

    // Write side only looks at registered flags, so a freed bank opens next cycle.
    assign in_ready  = !r_full[r_wr_sel];
    assign w_capture = in_valid && in_ready;

    // Frame storage; contents need no reset because the full flags gate them.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_bank_real[r_wr_sel] <= in_real;
            r_bank_img[r_wr_sel]  <= in_img;
        end
    end

    // Next-state logic for flags, selects, sample counter and read FSM.
    always_comb begin
        w_full_next   = r_full;
        w_rd_sel_next = r_rd_sel;
        w_cnt_next    = r_cnt;
        if (w_capture) begin
            w_full_next[r_wr_sel] = 1'b1;
        end
        case (r_state)
            STREAM: begin
                if (out_ready) begin
                    if (r_cnt == 4'hF) begin
                        w_full_next[r_rd_sel] = 1'b0;
                        w_rd_sel_next         = ~r_rd_sel;
                        w_cnt_next            = 4'h0;
                    end else begin
                        w_cnt_next = r_cnt + 4'h1;
                    end
                end
            end
            default: begin
                w_cnt_next = r_cnt;
            end
        endcase
        // STREAM exactly when the bank about to be read holds a frame.
        w_state_next = w_full_next[w_rd_sel_next] ? STREAM : IDLE;
    end

    // State register for flags, selects, counter and FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_cnt    <= 4'h0;
            r_state  <= IDLE;
        end else begin
            r_full   <= w_full_next;
            r_rd_sel <= w_rd_sel_next;
            r_cnt    <= w_cnt_next;
            r_state  <= w_state_next;
            if (w_capture) begin
                r_wr_sel <= ~r_wr_sel;
            end
        end
    end

    // Natural-order bin n lives in butterfly lane bitrev4(n).
    assign w_lane     = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
    assign w_raw_real = r_bank_real[r_rd_sel][{w_lane, 5'b00000} +: 32];
    assign w_raw_img  = r_bank_img[r_rd_sel][{w_lane, 5'b00000} +: 32];

    assign out_valid = (r_state == STREAM);
    assign out_index = r_cnt;
    assign out_last  = out_valid && (r_cnt == 4'hF);
    assign out_real  = out_valid ? f_scale(w_raw_real) : 32'd0;
    assign out_img   = out_valid ? f_scale(w_raw_img)  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fft16_unloader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fft16_unloader
// Description : Self-checking bench for fft16_unloader (SCALE_SHIFT 0 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft16_unloader;

    logic         clk;
    logic         rst;
    logic [511:0] in_real;
    logic [511:0] in_img;
    logic         in_valid;
    logic         out_ready;

    logic         rdy0, rdy4, val0, val4, last0, last4;
    logic [31:0]  re0, re4, im0, im4;
    logic [3:0]   idx0, idx4;

    int n_vec;
    int n_err;

    fft16_unloader #(.SCALE_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_real(in_real), .in_img(in_img),
        .in_valid(in_valid), .in_ready(rdy0), .out_real(re0), .out_img(im0),
        .out_index(idx0), .out_last(last0), .out_valid(val0), .out_ready(out_ready)
    );

    fft16_unloader #(.SCALE_SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .in_real(in_real), .in_img(in_img),
        .in_valid(in_valid), .in_ready(rdy4), .out_real(re4), .out_img(im4),
        .out_index(idx4), .out_last(last4), .out_valid(val4), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_lane(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (((n >> i) & 1) == 1) r = r + (1 << (3 - i));
        return r;
    endfunction

    function automatic logic [31:0] lane(input logic [511:0] f, input int k);
        return f[32*k +: 32];
    endfunction

    function automatic logic [31:0] ref_scale(input logic [31:0] w, input int sh);
        int e;
        e = int'(w[30:23]);
        if (sh == 0 || e == 255) return w;
        if (e <= sh) return {w[31], 31'd0};
        return {w[31], 8'(e - sh), w[22:0]};
    endfunction

    function automatic logic [31:0] f32_of_int(input int k);
        int msb;
        logic [31:0] m;
        if (k == 0) return 32'd0;
        msb = 0;
        for (int i = 0; i < 31; i++) if (((k >> i) & 1) == 1) msb = i;
        m = 32'(k) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic logic [511:0] rand_frame();
        logic [511:0] f;
        logic [31:0]  w;
        for (int k = 0; k < 16; k++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[30:23] = 8'hFF;
                1: w[30:23] = 8'($urandom_range(0, 5));
                default: ;
            endcase
            f[32*k +: 32] = w;
        end
        return f;
    endfunction

    task automatic test_reset();
        rst = 1; in_valid = 1; in_real = rand_frame(); out_ready = 1;
        repeat (3) tick();
        n_vec++; if (val0 !== 1'b0)   begin n_err++; $display("FAIL reset_valid got=%b exp=0", val0); end
        n_vec++; if (rdy0 !== 1'b1)   begin n_err++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
        n_vec++; if (idx0 !== 4'd0)   begin n_err++; $display("FAIL reset_index got=%0d exp=0", idx0); end
        n_vec++; if (last0 !== 1'b0)  begin n_err++; $display("FAIL reset_last got=%b exp=0", last0); end
        n_vec++; if (re0 !== 32'd0 || im0 !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h/%h exp=0/0", re0, im0); end
        rst = 0; in_valid = 0;
        tick();
        n_vec++; if (val0 !== 1'b0)   begin n_err++; $display("FAIL reset_ignore_valid got=%b exp=0", val0); end
    endtask

    task automatic test_ramp();
        logic [511:0] f;
        for (int k = 0; k < 16; k++) f[32*k +: 32] = f32_of_int(k);
        in_real = f; in_img = '0; in_valid = 1; out_ready = 1;
        n_vec++; if (val0 !== 1'b0) begin n_err++; $display("FAIL ramp_precapture_valid got=%b exp=0", val0); end
        tick();
        in_valid = 0;
        for (int n = 0; n < 16; n++) begin
            n_vec++; if (val0 !== 1'b1) begin n_err++; $display("FAIL ramp_valid n=%0d got=%b exp=1", n, val0); end
            n_vec++; if (idx0 !== 4'(n)) begin n_err++; $display("FAIL ramp_index got=%0d exp=%0d", idx0, n); end
            n_vec++; if (re0 !== f32_of_int(ref_lane(n))) begin n_err++; $display("FAIL ramp_real n=%0d got=%h exp=%h", n, re0, f32_of_int(ref_lane(n))); end
            n_vec++; if (im0 !== 32'd0) begin n_err++; $display("FAIL ramp_img n=%0d got=%h exp=0", n, im0); end
            n_vec++; if (last0 !== (n == 15)) begin n_err++; $display("FAIL ramp_last n=%0d got=%b exp=%b", n, last0, (n == 15)); end
            tick();
        end
        n_vec++; if (val0 !== 1'b0 || re0 !== 32'd0 || last0 !== 1'b0) begin n_err++; $display("FAIL ramp_after got=%b/%h/%b exp=0/0/0", val0, re0, last0); end
    endtask

    task automatic test_backpressure();
        logic [511:0] fa, fb, fc, ia, ib, ic;
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        ia = rand_frame(); ib = rand_frame(); ic = rand_frame();
        out_ready = 0; in_real = fa; in_img = ia; in_valid = 1;
        n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%b exp=1", rdy0); end
        tick();
        in_real = fb; in_img = ib;
        n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL bp_ready2 got=%b exp=1", rdy0); end
        n_vec++; if (val0 !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b exp=1", val0); end
        tick();
        in_real = fc; in_img = ic;
        n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_ready3 got=%b exp=0", rdy0); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got=%b exp=0", rdy0); end
            n_vec++; if (idx0 !== 4'd0 || re0 !== lane(fa, 0)) begin n_err++; $display("FAIL bp_hold_data got=%0d/%h exp=0/%h", idx0, re0, lane(fa, 0)); end
        end
        out_ready = 1;
        for (int n = 0; n < 16; n++) begin
            n_vec++; if (idx0 !== 4'(n) || re0 !== lane(fa, ref_lane(n))) begin n_err++; $display("FAIL bp_f1 n=%0d got=%0d/%h exp=%0d/%h", n, idx0, re0, n, lane(fa, ref_lane(n))); end
            n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL bp_f1_ready n=%0d got=%b exp=0", n, rdy0); end
            tick();
        end
        for (int n = 0; n < 16; n++) begin
            n_vec++; if (val0 !== 1'b1 || idx0 !== 4'(n) || re0 !== lane(fb, ref_lane(n)) || im0 !== lane(ib, ref_lane(n))) begin
                n_err++; $display("FAIL bp_f2 n=%0d got=%b/%0d/%h/%h exp=1/%0d/%h/%h", n, val0, idx0, re0, im0, n, lane(fb, ref_lane(n)), lane(ib, ref_lane(n)));
            end
            n_vec++; if (rdy0 !== (n == 0)) begin n_err++; $display("FAIL bp_f2_ready n=%0d got=%b exp=%b", n, rdy0, (n == 0)); end
            tick();
            if (n == 0) in_valid = 0;
        end
        for (int n = 0; n < 16; n++) begin
            n_vec++; if (val0 !== 1'b1 || idx0 !== 4'(n) || re0 !== lane(fc, ref_lane(n)) || im0 !== lane(ic, ref_lane(n))) begin
                n_err++; $display("FAIL bp_f3 n=%0d got=%b/%0d/%h/%h exp=1/%0d/%h/%h", n, val0, idx0, re0, im0, n, lane(fc, ref_lane(n)), lane(ic, ref_lane(n)));
            end
            tick();
        end
        n_vec++; if (val0 !== 1'b0) begin n_err++; $display("FAIL bp_end_valid got=%b exp=0", val0); end
    endtask

    task automatic test_toggle();
        logic [511:0] f;
        logic [15:0]  mask;
        int acc;
        f = rand_frame(); mask = '0; acc = 0;
        in_real = f; in_img = rand_frame(); in_valid = 1; out_ready = 0;
        tick();
        in_valid = 0;
        for (int c = 0; c < 64 && acc < 16; c++) begin
            out_ready = (c % 2 == 0);
            n_vec++; if (val0 !== 1'b1 || idx0 !== 4'(acc) || re0 !== lane(f, ref_lane(acc)) || last0 !== (acc == 15)) begin
                n_err++; $display("FAIL tog_sample c=%0d got=%b/%0d/%h/%b exp=1/%0d/%h/%b", c, val0, idx0, re0, last0, acc, lane(f, ref_lane(acc)), (acc == 15));
            end
            if (out_ready) begin
                n_vec++; if (mask[idx0] !== 1'b0) begin n_err++; $display("FAIL tog_repeat index=%0d got=seen exp=new", idx0); end
                mask[idx0] = 1'b1;
                acc++;
            end
            tick();
        end
        n_vec++; if (mask !== 16'hFFFF) begin n_err++; $display("FAIL tog_unique got=%h exp=ffff", mask); end
        n_vec++; if (val0 !== 1'b0) begin n_err++; $display("FAIL tog_end_valid got=%b exp=0", val0); end
    endtask

    task automatic test_scale();
        logic [511:0] f, im;
        logic [31:0]  tbl [4];
        logic [31:0]  e;
        int l;
        tbl[0] = 32'h3F800000; tbl[1] = 32'h3D800000; tbl[2] = 32'h00000000; tbl[3] = 32'hFF800000;
        f = rand_frame(); im = rand_frame();
        f[31:0] = 32'h41800000; f[63:32] = 32'h3F800000; f[95:64] = 32'h02000000; f[127:96] = 32'hFF800000;
        in_real = f; in_img = im; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        for (int n = 0; n < 16; n++) begin
            l = ref_lane(n);
            e = (l < 4) ? tbl[l] : ref_scale(lane(f, l), 4);
            n_vec++; if (re4 !== e) begin n_err++; $display("FAIL scale_real lane=%0d got=%h exp=%h", l, re4, e); end
            n_vec++; if (im4 !== ref_scale(lane(im, l), 4)) begin n_err++; $display("FAIL scale_img lane=%0d got=%h exp=%h", l, im4, ref_scale(lane(im, l), 4)); end
            n_vec++; if (re0 !== lane(f, l)) begin n_err++; $display("FAIL scale_pass lane=%0d got=%h exp=%h", l, re0, lane(f, l)); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        logic [511:0] fa, fb, fd;
        fa = rand_frame(); fb = rand_frame(); fd = rand_frame();
        out_ready = 0; in_valid = 1; in_real = fa;
        tick();
        in_real = fb;
        tick();
        in_valid = 0; out_ready = 1;
        for (int n = 0; n < 7; n++) tick();
        n_vec++; if (val0 !== 1'b1 || idx0 !== 4'd7) begin n_err++; $display("FAIL rstm_pre got=%b/%0d exp=1/7", val0, idx0); end
        #1 rst = 1;
        #1;
        n_vec++; if (val0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL rstm_async got=%b/%b exp=0/1", val0, rdy0); end
        n_vec++; if (idx0 !== 4'd0 || re0 !== 32'd0 || last0 !== 1'b0) begin n_err++; $display("FAIL rstm_outputs got=%0d/%h/%b exp=0/0/0", idx0, re0, last0); end
        in_valid = 1; in_real = rand_frame();
        tick(); tick();
        rst = 0; in_valid = 0;
        tick();
        n_vec++; if (val0 !== 1'b0 || rdy0 !== 1'b1) begin n_err++; $display("FAIL rstm_discard got=%b/%b exp=0/1", val0, rdy0); end
        in_real = fd; in_valid = 1;
        tick();
        in_valid = 0;
        for (int n = 0; n < 16; n++) begin
            n_vec++; if (val0 !== 1'b1 || idx0 !== 4'(n) || re0 !== lane(fd, ref_lane(n))) begin
                n_err++; $display("FAIL rstm_stream n=%0d got=%b/%0d/%h exp=1/%0d/%h", n, val0, idx0, re0, n, lane(fd, ref_lane(n)));
            end
            tick();
        end
        n_vec++; if (val0 !== 1'b0) begin n_err++; $display("FAIL rstm_end_valid got=%b exp=0", val0); end
    endtask

    task automatic test_random();
        logic [511:0] q_re [$];
        logic [511:0] q_im [$];
        int  pos, left, l, c;
        bit  ev, er;
        pos = 0; left = 40;
        for (c = 0; c < 4000; c++) begin
            if (left == 0 && q_re.size() == 0) break;
            ev = (q_re.size() > 0);
            er = (q_re.size() < 2);
            n_vec++; if (val0 !== ev || val4 !== ev) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b/%b exp=%b", c, val0, val4, ev); end
            n_vec++; if (rdy0 !== er || rdy4 !== er) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b/%b exp=%b", c, rdy0, rdy4, er); end
            if (ev) begin
                l = ref_lane(pos);
                n_vec++; if (idx0 !== 4'(pos) || last0 !== (pos == 15)) begin n_err++; $display("FAIL rnd_index c=%0d got=%0d/%b exp=%0d/%b", c, idx0, last0, pos, (pos == 15)); end
                n_vec++; if (re0 !== lane(q_re[0], l) || im0 !== lane(q_im[0], l)) begin n_err++; $display("FAIL rnd_data0 c=%0d got=%h/%h exp=%h/%h", c, re0, im0, lane(q_re[0], l), lane(q_im[0], l)); end
                n_vec++; if (re4 !== ref_scale(lane(q_re[0], l), 4) || im4 !== ref_scale(lane(q_im[0], l), 4)) begin
                    n_err++; $display("FAIL rnd_data4 c=%0d got=%h/%h exp=%h/%h", c, re4, im4, ref_scale(lane(q_re[0], l), 4), ref_scale(lane(q_im[0], l), 4));
                end
            end else begin
                n_vec++; if (re0 !== 32'd0 || im4 !== 32'd0 || last0 !== 1'b0) begin n_err++; $display("FAIL rnd_idle c=%0d got=%h/%h/%b exp=0/0/0", c, re0, im4, last0); end
            end
            in_valid  = (left > 0) && ($urandom_range(0, 2) != 0);
            in_real   = rand_frame();
            in_img    = rand_frame();
            out_ready = ($urandom_range(0, 3) != 0);
            if (ev && out_ready) begin
                pos++;
                if (pos == 16) begin
                    void'(q_re.pop_front());
                    void'(q_im.pop_front());
                    pos = 0;
                end
            end
            if (in_valid && er) begin
                q_re.push_back(in_real);
                q_im.push_back(in_img);
                left--;
            end
            tick();
        end
        in_valid = 0;
        n_vec++; if (c >= 4000) begin n_err++; $display("FAIL rnd_timeout got=%0d cycles exp=<4000", c); end
    endtask

    initial begin
        clk = 0; rst = 1; in_valid = 0; out_ready = 0; in_real = '0; in_img = '0;
        n_vec = 0; n_err = 0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_toggle();
        test_scale();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
